// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: tracks one outstanding data-memory access
// (IDLE -> WAIT -> DONE) and derives the stall vector, flush and error strobes.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       mem_access_i,
    input  logic       dmem_ack_i,
    input  logic       excp_i,
    output logic [5:0] stall_o,
    output logic       flush_o,
    output logic       dmem_req_o,
    output logic       mem_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       launch_s;
    logic       timeout_s;
    logic       mem_stall_s;

    // State and wait-cycle counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic; an exception always aborts to IDLE
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (excp_i) begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (mem_access_i) begin
                        state_nxt_s = S_WAIT;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                    cnt_nxt_s = 8'd0;
                end
                S_WAIT: begin
                    // Ack takes precedence over an expiring counter
                    if (dmem_ack_i) begin
                        state_nxt_s = S_DONE;
                        cnt_nxt_s   = 8'd0;
                    end else if (cnt_r == LAST_CNT) begin
                        state_nxt_s = S_IDLE;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = S_WAIT;
                        cnt_nxt_s   = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                    end
                end
                S_DONE: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end
    end

    // Output decode: memory request, stall vector, flush and error strobes
    always_comb begin
        launch_s    = 1'b0;
        timeout_s   = 1'b0;
        mem_stall_s = 1'b0;
        dmem_req_o  = 1'b0;
        flush_o     = 1'b0;
        mem_err_o   = 1'b0;
        stall_o     = 6'b000000;
        if (!rst) begin
            dmem_req_o = 1'b0;
            flush_o    = 1'b0;
            mem_err_o  = 1'b0;
            stall_o    = 6'b000000;
        end else begin
            launch_s    = (state_r == S_IDLE) && mem_access_i;
            timeout_s   = (state_r == S_WAIT) && !dmem_ack_i && (cnt_r == LAST_CNT);
            mem_stall_s = launch_s || ((state_r == S_WAIT) && !dmem_ack_i);
            flush_o     = excp_i || timeout_s;
            mem_err_o   = timeout_s && !excp_i;
            dmem_req_o  = !excp_i && (launch_s || (state_r == S_WAIT));
            if (flush_o) begin
                stall_o = 6'b000000;
            end else if (mem_stall_s) begin
                stall_o = 6'b011111;
            end else if (stallreq_ex_i) begin
                stall_o = 6'b001111;
            end else if (stallreq_id_i) begin
                stall_o = 6'b000111;
            end else begin
                stall_o = 6'b000000;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a reference model.
module tb_pipe_stall_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       stallreq_id_i;
    logic       stallreq_ex_i;
    logic       mem_access_i;
    logic       dmem_ack_i;
    logic       excp_i;
    logic [5:0] stall_o;
    logic       flush_o;
    logic       dmem_req_o;
    logic       mem_err_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 1'b0;

    // Reference model: m_wait = -1 with no access outstanding, else WAIT cycles already spent
    int m_wait = -1;
    bit m_done = 1'b0;

    pipe_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i),
        .mem_access_i (mem_access_i),
        .dmem_ack_i   (dmem_ack_i),
        .excp_i       (excp_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .dmem_req_o   (dmem_req_o),
        .mem_err_o    (mem_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic expect_all(input string name, input bit req, input logic [5:0] stall,
                              input bit flush, input bit err);
        chk({name, "_req"},   {5'b0, dmem_req_o}, {5'b0, req});
        chk({name, "_stall"}, stall_o,            stall);
        chk({name, "_flush"}, {5'b0, flush_o},    {5'b0, flush});
        chk({name, "_err"},   {5'b0, mem_err_o},  {5'b0, err});
    endtask

    // Apply one cycle of inputs just after the rising edge; return at the falling edge
    task automatic drive(input bit r, input bit id, input bit ex, input bit ma,
                         input bit ack, input bit exc);
        @(posedge clk);
        #1;
        rst           = r;
        stallreq_id_i = id;
        stallreq_ex_i = ex;
        mem_access_i  = ma;
        dmem_ack_i    = ack;
        excp_i        = exc;
        @(negedge clk);
    endtask

    // Per-cycle model comparison
    always @(negedge clk) begin : model
        bit         waiting;
        bit         launching;
        bit         expired;
        bit         e_req;
        bit         e_flush;
        bit         e_err;
        logic [5:0] e_stall;
        if (run) begin
            if (!rst) begin
                e_req   = 1'b0;
                e_flush = 1'b0;
                e_err   = 1'b0;
                e_stall = 6'b000000;
                m_wait  = -1;
                m_done  = 1'b0;
            end else begin
                waiting   = (m_wait >= 0);
                launching = !waiting && !m_done && mem_access_i;
                expired   = waiting && !dmem_ack_i && (m_wait == TO - 1);
                e_flush   = excp_i || expired;
                e_err     = expired && !excp_i;
                e_req     = !excp_i && (launching || waiting);
                if (e_flush)                                     e_stall = 6'b000000;
                else if (launching || (waiting && !dmem_ack_i))  e_stall = 6'b011111;
                else if (stallreq_ex_i)                          e_stall = 6'b001111;
                else if (stallreq_id_i)                          e_stall = 6'b000111;
                else                                             e_stall = 6'b000000;
                if (excp_i || expired) begin
                    m_wait = -1;
                    m_done = 1'b0;
                end else if (waiting && dmem_ack_i) begin
                    m_wait = -1;
                    m_done = 1'b1;
                end else if (waiting) begin
                    m_wait = m_wait + 1;
                end else if (launching) begin
                    m_wait = 0;
                    m_done = 1'b0;
                end else begin
                    m_done = 1'b0;
                end
            end
            chk("mdl_req",   {5'b0, dmem_req_o}, {5'b0, e_req});
            chk("mdl_stall", stall_o,            e_stall);
            chk("mdl_flush", {5'b0, flush_o},    {5'b0, e_flush});
            chk("mdl_err",   {5'b0, mem_err_o},  {5'b0, e_err});
        end
    end

    initial begin
        rst = 1'b0; stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0;
        mem_access_i = 1'b0; dmem_ack_i = 1'b0; excp_i = 1'b0;
        run = 1'b1;

        // Reset holds every output low whatever the inputs
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); expect_all("rst_a", 1'b0, 6'b000000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("rst_b", 1'b0, 6'b000000, 1'b0, 1'b0);

        // Launch in first cycle after reset, ack on 3rd WAIT cycle, DONE ignores new access
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("ack_launch", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("ack_w1", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("ack_w2", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_all("ack_w3", 1'b1, 6'b000000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("ack_done", 1'b0, 6'b000000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_all("ack_idle", 1'b0, 6'b000000, 1'b0, 1'b0);

        // Stall priority, then an unanswered access times out on the 4th WAIT cycle
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); expect_all("pri_ex", 1'b0, 6'b001111, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("pri_id", 1'b0, 6'b000111, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); expect_all("pri_mem", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("to_w1", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); expect_all("to_w2", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("to_w3", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); expect_all("to_w4", 1'b1, 6'b000000, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("to_idle", 1'b0, 6'b000000, 1'b0, 1'b0);

        // Exception in 2nd WAIT cycle aborts; a late ack is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("ex_launch", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("ex_w1", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); expect_all("ex_w2", 1'b0, 6'b000000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_all("ex_idle", 1'b0, 6'b000000, 1'b0, 1'b0);

        // Ack coinciding with the last counter value wins
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("at_launch", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("at_w1", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("at_w2", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("at_w3", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); expect_all("at_w4", 1'b1, 6'b000000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("at_done", 1'b0, 6'b000111, 1'b0, 1'b0);

        // Reset mid-WAIT aborts silently; access relaunches right after release
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("rw_launch", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("rw_w1", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("rw_rst", 1'b0, 6'b000000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_all("rw_relaunch", 1'b1, 6'b011111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_all("rw_w1b", 1'b1, 6'b011111, 1'b0, 1'b0);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
        end

        @(posedge clk);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
